tcdm_apb_bridge: RTL and testbench
==================================

TCDM_APB_BRIDGE -- requirements
Module: tcdm_apb_bridge

Interface
REQ-001 Parameters SHALL be: APB_ADDR_WIDTH, 32, APB address width; APB_DATA_WIDTH, 32, data width; TIMEOUT_CYCLES, 255, maximum ACCESS cycles before forced error (0 = timeout disabled).
REQ-002 The block SHALL have one clock and a synchronous active-low reset: clk_i  in  1  clock; rst_ni  in  1  synchronous active-low reset.
REQ-003 TCDM slave ports SHALL be: req_i  in  1  request; add_i  in  APB_ADDR_WIDTH  address; wen_i  in  1  1=read 0=write; wdata_i  in  APB_DATA_WIDTH  write data; be_i  in  APB_DATA_WIDTH/8  byte enables; gnt_o  out  1  grant; r_valid_o  out  1  response valid; r_rdata_o  out  APB_DATA_WIDTH  read data; r_opc_o  out  1  error flag.
REQ-004 APB master ports SHALL be: paddr_o  out  APB_ADDR_WIDTH; pwdata_o  out  APB_DATA_WIDTH; pwrite_o  out  1; pstrb_o  out  APB_DATA_WIDTH/8; psel_o  out  1; penable_o  out  1; prdata_i  in  APB_DATA_WIDTH; pready_i  in  1; pslverr_i  in  1. These ports SHALL feed the peripheral bus APB slave port directly.

Function
REQ-005 FSM states SHALL be IDLE, SETUP, ACCESS, RESP, with at most one transaction outstanding.
REQ-006 IDLE: gnt_o = req_i (combinational). On req_i&&gnt_o, add_i, wdata_i, ~wen_i, and be_i SHALL be registered into paddr_o, pwdata_o, pwrite_o, and pstrb_o, then -> SETUP. gnt_o SHALL be 0 in all other states.
REQ-007 SETUP: psel_o=1, penable_o=0 for exactly one cycle, then -> ACCESS.
REQ-008 ACCESS: psel_o=1, penable_o=1. pready_i SHALL be sampled only in ACCESS; on pready_i=1, capture pslverr_i into the error flag and prdata_i into r_rdata_o for reads (0 for writes), then -> RESP.
REQ-009 paddr_o, pwdata_o, pwrite_o, and pstrb_o SHALL remain stable from SETUP through the last ACCESS cycle and SHALL hold their values while IDLE.
REQ-010 Timeout: a counter of width $clog2(TIMEOUT_CYCLES+1) SHALL clear on entry to ACCESS and increment on each ACCESS cycle with pready_i=0. When TIMEOUT_CYCLES!=0 and the count reaches TIMEOUT_CYCLES-1 with pready_i=0, the block SHALL -> RESP with error=1 and r_rdata_o=0.
REQ-011 If pready_i=1 in the same cycle the timeout fires, pready_i SHALL win, and the error flag SHALL equal pslverr_i.
REQ-012 RESP: r_valid_o=1 for exactly one cycle, r_opc_o=error flag, psel_o=0, penable_o=0, then -> IDLE.
REQ-013 r_rdata_o SHALL hold its value until the next capture; r_opc_o SHALL be 0 outside RESP.
REQ-014 Minimum latency SHALL be: grant cycle T, SETUP T+1, ACCESS T+2, r_valid_o at T+3; minimum request spacing SHALL be 4 cycles.
REQ-015 req_i deasserting after grant SHALL NOT affect the transaction in flight; inputs in non-IDLE states SHALL be ignored.
REQ-016 psel_o and penable_o SHALL be driven from registers, and r_valid_o SHALL be decoded from registered state only (no combinational path from APB inputs).

Reset
REQ-017 At a clock edge with rst_ni=0, state SHALL -> IDLE, and the counter, psel_o, penable_o, pwrite_o, r_valid_o, r_opc_o, paddr_o, pwdata_o, pstrb_o, and r_rdata_o SHALL all be 0.
REQ-018 Reset mid-transaction SHALL abandon the transfer with no r_valid_o pulse; psel_o SHALL be 0 from the first edge sampled with rst_ni=0.
REQ-019 After reset release, the first cycle SHALL be IDLE, with gnt_o following req_i.

Verification
REQ-020 Read of 0x1A10_2000 with pready_i=1 on the first ACCESS cycle and prdata_i=0xCAFE_F00D -> r_valid_o at T+3, r_rdata_o=0xCAFE_F00D, r_opc_o=0.
REQ-021 Write of 0x1234_5678 with be_i=4'b0011 to 0x1A10_4004 -> pwrite_o=1, pstrb_o=4'b0011, pwdata_o=0x1234_5678 stable across SETUP and ACCESS; response r_opc_o=0, r_rdata_o=0.
REQ-022 TIMEOUT_CYCLES=4 with pready_i held 0 -> exactly 4 ACCESS cycles, then r_valid_o=1, r_opc_o=1, r_rdata_o=0.
REQ-023 TIMEOUT_CYCLES=4 with pready_i=1 and pslverr_i=0 on the 4th ACCESS cycle -> r_opc_o=0 (pready wins); with pslverr_i=1 -> r_opc_o=1.
REQ-024 Back-to-back requests with req_i held high -> gnt_o pulses every 4 cycles, and psel_o drops for at least one cycle between transfers.
REQ-025 rst_ni=0 asserted during ACCESS -> psel_o=0 after that edge, no r_valid_o pulse, and the next request completes normally.

Source files
------------

// File: rtl/tcdm_apb_bridge.sv
// -----------------------------------------------------------------------------
// tcdm_apb_bridge
//
// Converts single TCDM requests into APB transfers, one at a time.
// A request is granted combinationally while idle; its address, data, write
// flag and byte enables are registered and held on the APB side for the whole
// transfer. The APB completion (or a timeout) produces a one-cycle TCDM
// response carrying read data and an error flag.
//
// Ports
//   clk_i, rst_ni         clock, synchronous active-low reset
//   TCDM slave side       req_i, add_i, wen_i (1=read), wdata_i, be_i,
//                         gnt_o, r_valid_o, r_rdata_o, r_opc_o (error)
//   APB master side       paddr_o, pwdata_o, pwrite_o, pstrb_o, psel_o,
//                         penable_o, prdata_i, pready_i, pslverr_i
//
// Parameters
//   APB_ADDR_WIDTH, APB_DATA_WIDTH  bus widths
//   TIMEOUT_CYCLES                  ACCESS cycles before a forced error
//                                   response (0 disables the timeout)
// -----------------------------------------------------------------------------
module tcdm_apb_bridge #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  // TCDM slave
  input  logic                          req_i,
  input  logic [APB_ADDR_WIDTH-1:0]     add_i,
  input  logic                          wen_i,
  input  logic [APB_DATA_WIDTH-1:0]     wdata_i,
  input  logic [APB_DATA_WIDTH/8-1:0]   be_i,
  output logic                          gnt_o,
  output logic                          r_valid_o,
  output logic [APB_DATA_WIDTH-1:0]     r_rdata_o,
  output logic                          r_opc_o,
  // APB master
  output logic [APB_ADDR_WIDTH-1:0]     paddr_o,
  output logic [APB_DATA_WIDTH-1:0]     pwdata_o,
  output logic                          pwrite_o,
  output logic [APB_DATA_WIDTH/8-1:0]   pstrb_o,
  output logic                          psel_o,
  output logic                          penable_o,
  input  logic [APB_DATA_WIDTH-1:0]     prdata_i,
  input  logic                          pready_i,
  input  logic                          pslverr_i
);

  localparam int unsigned STRB_W     = APB_DATA_WIDTH / 8;
  // Keep the counter at least one bit wide when the timeout is disabled.
  localparam int unsigned CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                       state_reg,   state_next;
  logic [CNT_W-1:0]             cnt_reg,     cnt_next;
  logic                         err_reg,     err_next;
  logic [APB_DATA_WIDTH-1:0]    rdata_reg,   rdata_next;
  logic [APB_ADDR_WIDTH-1:0]    paddr_reg,   paddr_next;
  logic [APB_DATA_WIDTH-1:0]    pwdata_reg,  pwdata_next;
  logic                         pwrite_reg,  pwrite_next;
  logic [STRB_W-1:0]            pstrb_reg,   pstrb_next;
  logic                         psel_reg,    psel_next;
  logic                         penable_reg, penable_next;
  logic                         timeout_hit;

  // Timeout fires on the ACCESS cycle whose count has reached the limit;
  // pready_i is checked first in the FSM so a late completion still wins.
  assign timeout_hit = TIMEOUT_EN && (cnt_reg == CNT_LAST);

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    err_next    = err_reg;
    rdata_next  = rdata_reg;
    paddr_next  = paddr_reg;
    pwdata_next = pwdata_reg;
    pwrite_next = pwrite_reg;
    pstrb_next  = pstrb_reg;

    case (state_reg)
      IDLE: begin
        if (req_i) begin
          paddr_next  = add_i;
          pwdata_next = wdata_i;
          pwrite_next = ~wen_i;
          pstrb_next  = be_i;
          state_next  = SETUP;
        end
      end
      SETUP: begin
        cnt_next   = '0;
        state_next = ACCESS;
      end
      ACCESS: begin
        if (pready_i) begin
          err_next   = pslverr_i;
          rdata_next = pwrite_reg ? '0 : prdata_i;
          state_next = RESP;
        end else if (timeout_hit) begin
          err_next   = 1'b1;
          rdata_next = '0;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // APB strobes are registered copies of the upcoming state so that no
    // APB input can reach them combinationally.
    psel_next    = (state_next == SETUP) || (state_next == ACCESS);
    penable_next = (state_next == ACCESS);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
      rdata_reg   <= '0;
      paddr_reg   <= '0;
      pwdata_reg  <= '0;
      pwrite_reg  <= 1'b0;
      pstrb_reg   <= '0;
      psel_reg    <= 1'b0;
      penable_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      err_reg     <= err_next;
      rdata_reg   <= rdata_next;
      paddr_reg   <= paddr_next;
      pwdata_reg  <= pwdata_next;
      pwrite_reg  <= pwrite_next;
      pstrb_reg   <= pstrb_next;
      psel_reg    <= psel_next;
      penable_reg <= penable_next;
    end
  end

  assign gnt_o     = (state_reg == IDLE) && req_i;
  assign r_valid_o = (state_reg == RESP);
  assign r_opc_o   = (state_reg == RESP) && err_reg;
  assign r_rdata_o = rdata_reg;

  assign paddr_o   = paddr_reg;
  assign pwdata_o  = pwdata_reg;
  assign pwrite_o  = pwrite_reg;
  assign pstrb_o   = pstrb_reg;
  assign psel_o    = psel_reg;
  assign penable_o = penable_reg;

endmodule

// File: tb/tb_tcdm_apb_bridge.sv
// -----------------------------------------------------------------------------
// tb_tcdm_apb_bridge
//
// Directed scenarios with literal expectations followed by randomized traffic.
// A transaction-level reference model (offset of the current cycle from the
// grant, plus the cycle at which the response is due) predicts every output
// on every cycle; a compare process checks them on the falling edge.
// -----------------------------------------------------------------------------
module tb_tcdm_apb_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          req_i = 1'b0;
  logic [AW-1:0] add_i = '0;
  logic          wen_i = 1'b0;
  logic [DW-1:0] wdata_i = '0;
  logic [SW-1:0] be_i = '0;
  logic          gnt_o;
  logic          r_valid_o;
  logic [DW-1:0] r_rdata_o;
  logic          r_opc_o;
  logic [AW-1:0] paddr_o;
  logic [DW-1:0] pwdata_o;
  logic          pwrite_o;
  logic [SW-1:0] pstrb_o;
  logic          psel_o;
  logic          penable_o;
  logic [DW-1:0] prdata_i = '0;
  logic          pready_i = 1'b0;
  logic          pslverr_i = 1'b0;

  always #5 clk = ~clk;

  tcdm_apb_bridge #(
    .APB_ADDR_WIDTH (AW),
    .APB_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .add_i     (add_i),
    .wen_i     (wen_i),
    .wdata_i   (wdata_i),
    .be_i      (be_i),
    .gnt_o     (gnt_o),
    .r_valid_o (r_valid_o),
    .r_rdata_o (r_rdata_o),
    .r_opc_o   (r_opc_o),
    .paddr_o   (paddr_o),
    .pwdata_o  (pwdata_o),
    .pwrite_o  (pwrite_o),
    .pstrb_o   (pstrb_o),
    .psel_o    (psel_o),
    .penable_o (penable_o),
    .prdata_i  (prdata_i),
    .pready_i  (pready_i),
    .pslverr_i (pslverr_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. m_k is the number of cycles since the grant cycle;
  // cycle 1 is the setup phase, cycles 2.. are access cycles until the cycle
  // m_resp_at, which is the response cycle.
  // ---------------------------------------------------------------------------
  bit            m_valid = 1'b0;
  bit            m_busy  = 1'b0;
  int            m_k     = 0;
  int            m_resp_at = 0;
  logic [AW-1:0] m_paddr  = '0;
  logic [DW-1:0] m_pwdata = '0;
  logic          m_pwrite = 1'b0;
  logic [SW-1:0] m_pstrb  = '0;
  logic [DW-1:0] m_rdata  = '0;
  logic          m_err    = 1'b0;

  always @(posedge clk) begin
    if (!rst_ni) begin
      m_valid  <= 1'b1;
      m_busy   <= 1'b0;
      m_paddr  <= '0;
      m_pwdata <= '0;
      m_pwrite <= 1'b0;
      m_pstrb  <= '0;
      m_rdata  <= '0;
      m_err    <= 1'b0;
    end else if (!m_busy) begin
      if (req_i) begin
        m_busy    <= 1'b1;
        m_k       <= 1;
        m_resp_at <= 1000000;
        m_paddr   <= add_i;
        m_pwdata  <= wdata_i;
        m_pwrite  <= !wen_i;
        m_pstrb   <= be_i;
      end
    end else if (m_k == m_resp_at) begin
      m_busy <= 1'b0;
    end else begin
      m_k <= m_k + 1;
      if (m_k >= 2) begin
        if (pready_i) begin
          m_resp_at <= m_k + 1;
          m_err     <= pslverr_i;
          m_rdata   <= m_pwrite ? '0 : prdata_i;
        end else if ((m_k - 2) == (TO - 1)) begin
          m_resp_at <= m_k + 1;
          m_err     <= 1'b1;
          m_rdata   <= '0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("gnt",      gnt_o,     32'(!m_busy && req_i));
      chk("psel",     psel_o,    32'(m_busy && (m_k < m_resp_at)));
      chk("penable",  penable_o, 32'(m_busy && (m_k >= 2) && (m_k < m_resp_at)));
      chk("r_valid",  r_valid_o, 32'(m_busy && (m_k == m_resp_at)));
      chk("r_opc",    r_opc_o,   32'(m_busy && (m_k == m_resp_at) && m_err));
      chk("r_rdata",  r_rdata_o, m_rdata);
      chk("paddr",    paddr_o,   m_paddr);
      chk("pwdata",   pwdata_o,  m_pwdata);
      chk("pwrite",   pwrite_o,  32'(m_pwrite));
      chk("pstrb",    pstrb_o,   32'(m_pstrb));
    end
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read with pready_i raised on the given access cycle (1-based), checking
  // the response literally.
  task automatic read_on_access(input int n, input logic err, input logic [31:0] data);
    tick();
    req_i = 1'b1; wen_i = 1'b1; add_i = 32'h1A10_3000; pready_i = 1'b0;
    @(negedge clk); chk("late_gnt", gnt_o, 1);
    tick(); req_i = 1'b0;
    for (int i = 1; i < n; i++) tick();
    tick(); pready_i = 1'b1; pslverr_i = err; prdata_i = data;
    @(negedge clk); chk("late_penable", penable_o, 1);
    tick(); pready_i = 1'b0; pslverr_i = 1'b0;
    @(negedge clk);
    chk("late_rvalid", r_valid_o, 1);
    chk("late_opc",    r_opc_o,   32'(err));
    chk("late_rdata",  r_rdata_o, data);
  endtask

  initial begin
    int  acc;
    bit  seen;
    int  last;
    int  ngnt;

    // Reset state
    tick(); tick();
    @(negedge clk);
    chk("rst_psel",    psel_o,    0);
    chk("rst_penable", penable_o, 0);
    chk("rst_rvalid",  r_valid_o, 0);
    chk("rst_opc",     r_opc_o,   0);
    chk("rst_paddr",   paddr_o,   0);
    chk("rst_pwdata",  pwdata_o,  0);
    chk("rst_pstrb",   pstrb_o,   0);
    chk("rst_pwrite",  pwrite_o,  0);
    chk("rst_rdata",   r_rdata_o, 0);

    // Read, ready on first access cycle; first cycle after release is IDLE
    tick();
    rst_ni = 1'b1; req_i = 1'b1; add_i = 32'h1A10_2000; wen_i = 1'b1; be_i = 4'hF;
    @(negedge clk); chk("rd_gnt", gnt_o, 1);
    tick(); req_i = 1'b0; add_i = 32'h0;
    @(negedge clk);
    chk("rd_setup_psel", psel_o, 1); chk("rd_setup_pen", penable_o, 0);
    chk("rd_paddr", paddr_o, 32'h1A10_2000); chk("rd_pwrite", pwrite_o, 0);
    tick(); pready_i = 1'b1; prdata_i = 32'hCAFE_F00D; pslverr_i = 1'b0;
    @(negedge clk); chk("rd_acc_psel", psel_o, 1); chk("rd_acc_pen", penable_o, 1);
    tick(); pready_i = 1'b0; prdata_i = 32'h0;
    @(negedge clk);
    chk("rd_rvalid", r_valid_o, 1); chk("rd_rdata", r_rdata_o, 32'hCAFE_F00D);
    chk("rd_opc", r_opc_o, 0); chk("rd_resp_psel", psel_o, 0);
    tick();
    @(negedge clk);
    chk("rd_rvalid_once", r_valid_o, 0); chk("rd_rdata_hold", r_rdata_o, 32'hCAFE_F00D);

    // Write with partial strobes
    tick();
    req_i = 1'b1; add_i = 32'h1A10_4004; wen_i = 1'b0; wdata_i = 32'h1234_5678; be_i = 4'b0011;
    @(negedge clk); chk("wr_gnt", gnt_o, 1);
    tick(); req_i = 1'b0; wdata_i = 32'hFFFF_FFFF; be_i = 4'hF;
    @(negedge clk);
    chk("wr_setup_pwrite", pwrite_o, 1); chk("wr_setup_pstrb", pstrb_o, 4'b0011);
    chk("wr_setup_pwdata", pwdata_o, 32'h1234_5678); chk("wr_setup_paddr", paddr_o, 32'h1A10_4004);
    tick(); pready_i = 1'b1; prdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("wr_acc_pwrite", pwrite_o, 1); chk("wr_acc_pstrb", pstrb_o, 4'b0011);
    chk("wr_acc_pwdata", pwdata_o, 32'h1234_5678);
    tick(); pready_i = 1'b0;
    @(negedge clk);
    chk("wr_rvalid", r_valid_o, 1); chk("wr_opc", r_opc_o, 0); chk("wr_rdata", r_rdata_o, 0);

    // Timeout with pready_i held low
    tick();
    req_i = 1'b1; wen_i = 1'b1; add_i = 32'h1A10_5000; pready_i = 1'b0;
    @(negedge clk); chk("to_gnt", gnt_o, 1);
    tick(); req_i = 1'b0;
    acc = 0; seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (psel_o && penable_o) acc++;
      if (r_valid_o) begin
        seen = 1'b1;
        chk("to_opc", r_opc_o, 1);
        chk("to_rdata", r_rdata_o, 0);
      end else begin
        tick();
      end
    end
    chk("to_response_seen", 32'(seen), 1);
    chk("to_access_cycles", acc, 4);

    // pready_i on the 4th access cycle beats the timeout
    read_on_access(4, 1'b0, 32'h0BAD_CAFE);
    read_on_access(4, 1'b1, 32'h1111_2222);

    // Back-to-back requests with req_i held high
    tick();
    req_i = 1'b1; wen_i = 1'b0; pready_i = 1'b1; pslverr_i = 1'b0;
    last = -1; ngnt = 0;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      if (gnt_o) begin
        if (last >= 0) chk("b2b_spacing", c - last, 4);
        chk("b2b_psel_gap", psel_o, 0);
        last = c;
        ngnt++;
      end
      tick();
      wdata_i = $urandom; add_i = $urandom;
    end
    chk("b2b_grants", ngnt, 5);
    req_i = 1'b0; pready_i = 1'b0;
    repeat (6) tick();

    // Reset during ACCESS
    req_i = 1'b1; wen_i = 1'b1; add_i = 32'h1A10_6000;
    @(negedge clk); chk("rs_gnt", gnt_o, 1);
    tick(); req_i = 1'b0;
    tick();
    @(negedge clk); chk("rs_in_access", penable_o, 1);
    tick(); rst_ni = 1'b0;
    tick(); rst_ni = 1'b1;
    @(negedge clk);
    chk("rs_psel", psel_o, 0); chk("rs_pen", penable_o, 0); chk("rs_rvalid", r_valid_o, 0);
    for (int c = 0; c < 5; c++) begin
      tick();
      @(negedge clk); chk("rs_no_rvalid", r_valid_o, 0);
    end
    tick();
    req_i = 1'b1; wen_i = 1'b1; add_i = 32'h1A10_7000; pready_i = 1'b1; prdata_i = 32'h1357_9BDF;
    @(negedge clk); chk("rs_next_gnt", gnt_o, 1);
    tick(); req_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (r_valid_o) begin
        seen = 1'b1;
        chk("rs_next_rdata", r_rdata_o, 32'h1357_9BDF);
        chk("rs_next_opc", r_opc_o, 0);
      end else begin
        tick();
      end
    end
    chk("rs_next_done", 32'(seen), 1);
    pready_i = 1'b0;

    // Randomized traffic, checked every cycle by the model
    for (int c = 0; c < 600; c++) begin
      tick();
      rst_ni    = ($urandom_range(0, 99) != 0);
      req_i     = $urandom_range(0, 1) != 0;
      add_i     = $urandom;
      wen_i     = $urandom_range(0, 1) != 0;
      wdata_i   = $urandom;
      be_i      = SW'($urandom);
      pready_i  = ($urandom_range(0, 2) == 0);
      prdata_i  = $urandom;
      pslverr_i = $urandom_range(0, 3) == 0;
    end
    tick();
    rst_ni = 1'b1; req_i = 1'b0;
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
